// File: rtl/arp_rx_parser_if.sv
// ARP receive parser bus: payload word stream in, frame CRC verdict in,
// parsed packet out under ready/valid, plus the drop-reason pulse.
interface arp_rx_parser_if #(
  parameter int DW = 16
);
  logic          in_valid;
  logic          in_sof;
  logic          in_eof;
  logic [DW-1:0] in_data;
  logic          crc_valid;
  logic          crc_match;
  logic          out_valid;
  logic          out_ready;
  logic          out_is_reply;
  logic [47:0]   out_sha;
  logic [31:0]   out_spa;
  logic [47:0]   out_tha;
  logic [31:0]   out_tpa;
  logic          err_pulse;
  logic [2:0]    err_code;

  modport master (
    output in_valid, in_sof, in_eof, in_data, crc_valid, crc_match, out_ready,
    input  out_valid, out_is_reply, out_sha, out_spa, out_tha, out_tpa,
           err_pulse, err_code
  );

  modport slave (
    input  in_valid, in_sof, in_eof, in_data, crc_valid, crc_match, out_ready,
    output out_valid, out_is_reply, out_sha, out_spa, out_tha, out_tpa,
           err_pulse, err_code
  );
endinterface

// File: rtl/arp_rx_parser.sv
// ARP receive parser: collects the 28-byte ARP payload (MSB-first words),
// checks the header, waits for the frame CRC verdict and holds the parsed
// packet until the consumer takes it. Drops are reported on err_pulse.
// Optional: define ARP_TPA_FILTER_EN to drop packets whose TPA is not local_ip.
module arp_rx_parser #(
  parameter int DW          = 16,
  parameter int CRC_TIMEOUT = 64
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [31:0]    local_ip,
  arp_rx_parser_if.slave bus
);
  localparam int NW = 224 / DW;
  localparam int CW = $clog2(NW);
  localparam int TW = $clog2(CRC_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(NW - 1);
  localparam logic [TW-1:0] TMAX = TW'(CRC_TIMEOUT - 1);

  localparam logic [2:0] E_HDR   = 3'd1;
  localparam logic [2:0] E_SHORT = 3'd2;
  localparam logic [2:0] E_CRC   = 3'd3;
  localparam logic [2:0] E_TMO   = 3'd4;
  localparam logic [2:0] E_BUSY  = 3'd5;
  localparam logic [2:0] E_ABORT = 3'd6;
  localparam logic [2:0] E_TPA   = 3'd7;

  typedef enum logic [2:0] {IDLE, RECV, PAD, WAIT_CRC, HOLD, DROP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [223:0]  pkt_q, pkt_d;
  logic          out_valid_q, out_valid_d;
  logic [160:0]  out_q, out_d;            // {is_reply, sha, spa, tha, tpa}
  logic          err_pulse_q, err_pulse_d;
  logic [2:0]    err_code_q, err_code_d;

  logic          sof, start, drop;
  logic [2:0]    drop_code;
  logic [223:0]  pkt_shift;
  logic          hdr_ok, tpa_ok;

  assign sof = bus.in_valid & bus.in_sof;

  // Words shift in at the bottom; after NW words word 0 sits at [223 -: DW].
  assign pkt_shift = {pkt_q[223-DW:0], bus.in_data};

  // Header is judged on the completed packet, i.e. as the last word lands.
  assign hdr_ok = (pkt_shift[223:208] == 16'h0001) &&
                  (pkt_shift[207:192] == 16'h0800) &&
                  (pkt_shift[191:184] == 8'd6)     &&
                  (pkt_shift[183:176] == 8'd4)     &&
                  ((pkt_shift[175:160] == 16'd1) || (pkt_shift[175:160] == 16'd2));

`ifdef ARP_TPA_FILTER_EN
  assign tpa_ok = (pkt_q[31:0] == local_ip);
`else
  assign tpa_ok = 1'b1;
  logic unused_local_ip;
  assign unused_local_ip = ^local_ip;
`endif

  // Top word of the shift register only ever leaves through pkt_q itself.
  logic unused_pkt_top;
  assign unused_pkt_top = ^pkt_q[223 -: DW];

  // Next-state, capture and error decisions.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tmr_d       = tmr_q;
    pkt_d       = pkt_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    err_pulse_d = 1'b0;
    err_code_d  = err_code_q;
    start       = 1'b0;
    drop        = 1'b0;
    drop_code   = E_HDR;

    case (state_q)
      IDLE, DROP: begin
        if (sof) start = 1'b1;
        else     state_d = IDLE;
      end
      RECV: begin
        if (sof) begin
          start       = 1'b1;
          err_pulse_d = 1'b1;
          err_code_d  = E_ABORT;
        end else if (bus.in_valid) begin
          pkt_d = pkt_shift;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            if (!hdr_ok) begin
              drop = 1'b1; drop_code = E_HDR;
            end else if (bus.in_eof) begin
              state_d = WAIT_CRC;
              tmr_d   = '0;
            end else begin
              state_d = PAD;
            end
          end else if (bus.in_eof) begin
            drop = 1'b1; drop_code = E_SHORT;
          end
        end
      end
      PAD: begin
        if (sof) begin
          start       = 1'b1;
          err_pulse_d = 1'b1;
          err_code_d  = E_ABORT;
        end else if (bus.in_valid && bus.in_eof) begin
          state_d = WAIT_CRC;
          tmr_d   = '0;
        end
      end
      WAIT_CRC: begin
        if (sof) begin
          start       = 1'b1;
          err_pulse_d = 1'b1;
          err_code_d  = E_ABORT;
        end else if (bus.crc_valid) begin
          if (!bus.crc_match) begin
            drop = 1'b1; drop_code = E_CRC;
          end else if (!tpa_ok) begin
            drop = 1'b1; drop_code = E_TPA;
          end else begin
            state_d     = HOLD;
            out_valid_d = 1'b1;
            out_d       = {pkt_q[175:160] == 16'd2, pkt_q[159:0]};
          end
        end else if (tmr_q == TMAX) begin
          // Timer stops at TMAX: it is never incremented past it.
          drop = 1'b1; drop_code = E_TMO;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
        if (sof) begin
          err_pulse_d = 1'b1;
          err_code_d  = E_BUSY;
        end
      end
      default: state_d = IDLE;
    endcase

    // The sof word is always word 0 of a fresh packet; its in_eof is ignored
    // since a complete ARP payload spans at least seven words.
    if (start) begin
      pkt_d   = pkt_shift;
      cnt_d   = CW'(1);
      state_d = RECV;
    end
    if (drop) begin
      state_d     = DROP;
      err_pulse_d = 1'b1;
      err_code_d  = drop_code;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      tmr_q       <= '0;
      pkt_q       <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      err_pulse_q <= 1'b0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmr_q       <= tmr_d;
      pkt_q       <= pkt_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      err_pulse_q <= err_pulse_d;
      err_code_q  <= err_code_d;
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_is_reply = out_q[160];
  assign bus.out_sha      = out_q[159:112];
  assign bus.out_spa      = out_q[111:80];
  assign bus.out_tha      = out_q[79:32];
  assign bus.out_tpa      = out_q[31:0];
  assign bus.err_pulse    = err_pulse_q;
  assign bus.err_code     = err_code_q;
endmodule

// File: tb/tb_arp_rx_parser.sv
// Bench for arp_rx_parser: one DW=16 and one DW=32 instance share a stimulus
// bus (sel steers it). Expected outcomes come from a byte-level ARP model.
module tb_arp_rx_parser;
  localparam int          TMO   = 64;
  localparam logic [31:0] MY_IP = 32'h0A00_0002;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        sel;   // 0: DW=16 instance, 1: DW=32 instance
  logic        in_valid, in_sof, in_eof, crc_valid, crc_match, out_ready;
  logic [31:0] wdata;

  arp_rx_parser_if #(.DW(16)) b16 ();
  arp_rx_parser_if #(.DW(32)) b32 ();

  assign b16.in_valid  = in_valid & ~sel;
  assign b16.in_sof    = in_sof;
  assign b16.in_eof    = in_eof;
  assign b16.in_data   = wdata[15:0];
  assign b16.crc_valid = crc_valid & ~sel;
  assign b16.crc_match = crc_match;
  assign b16.out_ready = out_ready & ~sel;
  assign b32.in_valid  = in_valid & sel;
  assign b32.in_sof    = in_sof;
  assign b32.in_eof    = in_eof;
  assign b32.in_data   = wdata;
  assign b32.crc_valid = crc_valid & sel;
  assign b32.crc_match = crc_match;
  assign b32.out_ready = out_ready & sel;

  arp_rx_parser #(.DW(16), .CRC_TIMEOUT(TMO)) dut16 (
    .clock(clock), .reset(reset), .local_ip(MY_IP), .bus(b16));
  arp_rx_parser #(.DW(32), .CRC_TIMEOUT(TMO)) dut32 (
    .clock(clock), .reset(reset), .local_ip(MY_IP), .bus(b32));

  logic         o_valid, o_err;
  logic [2:0]   o_code;
  logic [160:0] o_pkt;
  assign o_valid = sel ? b32.out_valid : b16.out_valid;
  assign o_err   = sel ? b32.err_pulse : b16.err_pulse;
  assign o_code  = sel ? b32.err_code  : b16.err_code;
  assign o_pkt   = sel ? {b32.out_is_reply, b32.out_sha, b32.out_spa, b32.out_tha, b32.out_tpa}
                       : {b16.out_is_reply, b16.out_sha, b16.out_spa, b16.out_tha, b16.out_tpa};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string tag, logic [255:0] got, logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Monitor: record drop pulses and handshakes; a held packet must not move.
  logic [2:0]   err_q[$];
  logic [160:0] out_q[$];
  logic         held = 1'b0;
  logic [160:0] held_pkt = '0;
  always @(negedge clock) begin
    if (reset) begin
      held <= 1'b0;
    end else begin
      if (o_err) err_q.push_back(o_code);
      if (held) chk("hold_stable", {o_valid, o_pkt}, {1'b1, held_pkt});
      if (o_valid && out_ready) out_q.push_back(o_pkt);
      held     <= o_valid && !out_ready;
      held_pkt <= o_pkt;
    end
  end

  // ---------------- reference model (byte level) ----------------
  logic [7:0] pb [28];

  task automatic build(logic [15:0] oper, logic [47:0] sha, logic [31:0] spa,
                       logic [47:0] tha, logic [31:0] tpa);
    logic [223:0] p;
    p = {16'h0001, 16'h0800, 8'd6, 8'd4, oper, sha, spa, tha, tpa};
    for (int i = 0; i < 28; i++) pb[i] = p[223-8*i -: 8];
  endtask

  function automatic bit hdr_ok();
    return pb[0] == 8'h00 && pb[1] == 8'h01 && pb[2] == 8'h08 && pb[3] == 8'h00 &&
           pb[4] == 8'd6 && pb[5] == 8'd4 && pb[6] == 8'h00 &&
           (pb[7] == 8'd1 || pb[7] == 8'd2);
  endfunction

  function automatic logic [160:0] exp_pkt();
    logic [160:0] r;
    r[160] = (pb[7] == 8'd2);
    for (int i = 8; i < 28; i++) r[159-8*(i-8) -: 8] = pb[i];
    return r;
  endfunction

  function automatic int model_err(bit early, int delay, bit match);
    if (early) return 2;
    if (!hdr_ok()) return 1;
    if (delay >= TMO) return 4;
    if (!match) return 3;
`ifdef ARP_TPA_FILTER_EN
    if ({pb[24], pb[25], pb[26], pb[27]} != MY_IP) return 7;
`endif
    return 0;
  endfunction

  function automatic int nwords();
    return sel ? 7 : 14;
  endfunction

  function automatic logic [31:0] word_of(int k);
    int          bpw;
    logic [31:0] w;
    bpw = sel ? 4 : 2;
    w   = '0;
    for (int j = 0; j < bpw; j++) w = {w[23:0], pb[k*bpw+j]};
    return w;
  endfunction

  // ---------------- drivers ----------------
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Idle cycles carry garbage on every qualified-by-valid signal.
  task automatic idle(int n);
    repeat (n) begin
      in_valid = 1'b0;
      in_sof   = 1'($urandom);
      in_eof   = 1'($urandom);
      wdata    = $urandom;
      cyc();
    end
    in_sof = 1'b0;
    in_eof = 1'b0;
  endtask

  task automatic put(logic [31:0] d, bit s, bit e, int gap);
    idle(gap);
    in_valid = 1'b1; in_sof = s; in_eof = e; wdata = d;
    cyc();
    in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
  endtask

  task automatic send(int nsend, int pad, bit eof_last, bit gaps);
    int total;
    total = nsend + pad;
    for (int k = 0; k < total; k++)
      put(k < nsend ? word_of(k) : $urandom, k == 0, eof_last && k == total - 1,
          gaps ? int'($urandom_range(0, 2)) : 0);
  endtask

  task automatic crc(int delay, bit match, bit exp_out);
    idle(delay);
    crc_valid = 1'b1; crc_match = match;
    @(negedge clock);
    chk("pre_latency", o_valid, 1'b0);
    cyc();
    crc_valid = 1'b0; crc_match = 1'($urandom);
    @(negedge clock);
    chk("out_latency", o_valid, exp_out);
  endtask

  task automatic hshake(int r);
    out_ready = 1'b0;
    idle(r);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
  endtask

  task automatic verdict(string tag, int exp_err, bit exp_out, logic [160:0] want);
    idle(3);
    chk({tag, "_nerr"}, err_q.size(), exp_err != 0);
    if (exp_err != 0 && err_q.size() > 0) chk({tag, "_code"}, err_q[0], exp_err);
    chk({tag, "_nout"}, out_q.size(), exp_out);
    if (exp_out && out_q.size() > 0) chk({tag, "_fields"}, out_q[0], want);
    err_q.delete();
    out_q.delete();
  endtask

  task automatic pkt(string tag, int pad, int delay, bit match, int r, bit gaps);
    int e;
    e = model_err(1'b0, delay, match);
    send(nwords(), pad, 1'b1, gaps);
    crc(delay, match, e == 0);
    hshake(r);
    verdict(tag, e, e == 0, exp_pkt());
  endtask

  task automatic rand_build();
    build(16'($urandom_range(1, 2)), {$urandom, 16'($urandom)}, $urandom,
          {$urandom, 16'($urandom)}, ($urandom_range(0, 3) == 0) ? $urandom : MY_IP);
  endtask

  // ---------------- scenarios ----------------
  logic [160:0] save;
  initial begin
    sel = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0; wdata = '0;
    crc_valid = 1'b0; crc_match = 1'b0; out_ready = 1'b0; reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_valid16", o_valid, 1'b0);
    chk("rst_err16", {o_err, o_code}, 4'h0);
    chk("rst_fields16", o_pkt, '0);
    sel = 1'b1; #1;
    chk("rst_valid32", o_valid, 1'b0);
    chk("rst_err32", {o_err, o_code}, 4'h0);
    chk("rst_fields32", o_pkt, '0);
    sel = 1'b0;
    cyc();

    // DW=16 request with exact field values
    build(16'd1, 48'h0011_2233_4455, 32'h0A00_0001, 48'h0, MY_IP);
    send(14, 0, 1'b1, 1'b0);
    crc(2, 1'b1, 1'b1);
    chk("req_reply_bit", o_pkt[160], 1'b0);
    chk("req_sha", o_pkt[159:112], 48'h0011_2233_4455);
    chk("req_spa", o_pkt[111:80], 32'h0A00_0001);
    chk("req_tpa", o_pkt[31:0], 32'h0A00_0002);
    hshake(1);
    verdict("req16", 0, 1'b1, exp_pkt());

    // DW=32 reply, 4 pad words, consumer stalls 5 cycles, then back to IDLE
    sel = 1'b1;
    build(16'd2, 48'hA1B2_C3D4_E5F6, 32'hC0A8_0105, 48'h0011_2233_4455, MY_IP);
    send(7, 4, 1'b1, 1'b0);
    crc(0, 1'b1, 1'b1);
    hshake(5);
    verdict("reply32", 0, 1'b1, exp_pkt());
    rand_build();
    pkt("after32", 0, 1, 1'b1, 0, 1'b0);

    // PAD abort on DW=32: second packet must parse
    build(16'd1, 48'h1, 32'h2, 48'h3, MY_IP);
    send(7, 2, 1'b0, 1'b0);
    rand_build();
    send(7, 0, 1'b1, 1'b0);
    crc(1, 1'b1, 1'b1);
    hshake(0);
    verdict("pad_abort", 6, 1'b1, exp_pkt());
    sel = 1'b0;

    // Bad ptype
    rand_build();
    pb[2] = 8'h86; pb[3] = 8'hDD;
    pkt("ptype", 0, 1, 1'b1, 0, 1'b0);

    // Early eof on word 9
    rand_build();
    send(10, 0, 1'b1, 1'b0);
    crc(1, 1'b1, 1'b0);
    hshake(0);
    verdict("short", model_err(1'b1, 1, 1'b1), 1'b0, '0);

    // CRC bad, timeout, and the last accepted cycle before timeout
    rand_build();
    pkt("crcbad", 0, 1, 1'b0, 0, 1'b0);
    rand_build();
    pkt("tmo", 0, TMO, 1'b1, 0, 1'b0);
    build(16'd1, 48'h5, 32'h6, 48'h7, MY_IP);
    pkt("tmo_edge", 0, TMO - 1, 1'b1, 0, 1'b0);

    // New sof while holding: held packet survives
    build(16'd2, 48'hDEAD_BEEF_0001, 32'h0A00_0003, 48'h0, MY_IP);
    send(14, 0, 1'b1, 1'b0);
    crc(0, 1'b1, 1'b1);
    save = exp_pkt();
    rand_build();
    send(14, 0, 1'b1, 1'b1);
    hshake(2);
    verdict("busy", 5, 1'b1, save);

    // sof in WAIT_CRC: abort, new packet parsed
    rand_build();
    send(14, 0, 1'b1, 1'b0);
    idle(3);
    build(16'd1, 48'h0A0B_0C0D_0E0F, 32'h0A00_0007, 48'h0, MY_IP);
    send(14, 0, 1'b1, 1'b0);
    crc(1, 1'b1, 1'b1);
    hshake(1);
    verdict("wait_abort", 6, 1'b1, exp_pkt());

    // Foreign TPA
    build(16'd1, 48'h0011_2233_4455, 32'h0A00_0001, 48'h0, 32'h0A00_0009);
    pkt("tpa", 0, 1, 1'b1, 0, 1'b0);

    // Reset mid-RECV: silent discard, then normal operation
    rand_build();
    send(5, 0, 1'b0, 1'b0);
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    @(negedge clock);
    chk("midrst_valid", o_valid, 1'b0);
    verdict("midrst", 0, 1'b0, '0);
    rand_build();
    pkt("post_rst", 0, 2, 1'b1, 0, 1'b0);

    // Randomized packets on both widths
    for (int n = 0; n < 40; n++) begin
      sel = 1'(n % 2);
      rand_build();
      if ($urandom_range(0, 6) == 0)
        pb[$urandom_range(0, 7)] ^= 8'(1 << $urandom_range(0, 7));
      pkt("rnd", sel ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 2)),
          ($urandom_range(0, 9) == 0) ? int'($urandom_range(60, 70)) : int'($urandom_range(0, 6)),
          $urandom_range(0, 5) != 0, int'($urandom_range(0, 3)), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    n_bad++;
    $display("FAIL watchdog: got timeout want completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
